// File: rtl/spi_mux_pkg.sv
// Shared types and constants for the SPI mode-0 master that feeds the LED
// output multiplexer.
//   - state encoding of the frame sequencer
//   - default timing constants (clk cycles)
//   - byte width and the packed beat payload captured on each handshake
//   - helpers to size the phase/delay counter
package spi_mux_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned BIT_CNT_W    = 3;

   localparam int unsigned DEF_CLK_DIV  = 4;
   localparam int unsigned DEF_CS_SETUP = 2;
   localparam int unsigned DEF_CS_HOLD  = 2;
   localparam int unsigned DEF_CS_IDLE  = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_NEXT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   // One accepted stream beat: the byte being shifted plus its end-of-frame flag.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } tx_beat_t;

   function automatic int unsigned max4(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c,
                                        input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Bits needed to hold values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = (max_val < 1) ? 1 : $clog2(max_val + 1);
      return w;
   endfunction

endpackage

// File: rtl/spi_mux_master_timer.sv
// spi_phase_timer: loadable down-counter with a terminal-count flag.
// Used for the chip-select setup, hold and idle delays and for SCK half-periods.
// Loading value N makes tc_c assert N clock cycles after the load edge, so a
// delay of P cycles is obtained by loading P-1.
// Ports:
//   clk       in  1      master clock
//   reset     in  1      asynchronous active-high reset
//   load      in  1      load load_val at this edge
//   load_val  in  CNT_W  value to load
//   tc_c      out 1      combinational: counter is at zero
module spi_phase_timer
   import spi_mux_pkg::*;
#(
   parameter int unsigned CNT_W = cnt_width(DEF_CS_IDLE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc_c
);

   logic [CNT_W-1:0] count;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign tc_c = (count == '0);

endmodule

// File: rtl/spi_mux_master.sv
// spi_mux_master: SPI mode-0 master transmitter feeding the LED output mux.
// Bytes arrive on a valid/ready stream; each frame is one chip-select
// assertion closed by tx_last. Data goes out MSB-first on spi_mosi, changing
// on SCK falling edges and sampled by the receiver on SCK rising edges.
// Ports:
//   clk         in  1  master clock
//   reset       in  1  asynchronous active-high reset (aborts any frame)
//   tx_data     in  8  byte to send
//   tx_valid    in  1  tx_data/tx_last valid
//   tx_last     in  1  byte closes the frame
//   tx_ready    out 1  byte accepted at this edge when tx_valid is high
//   spi_nCS     out 1  chip select, active low
//   spi_sck     out 1  serial clock, idle low
//   spi_mosi    out 1  serial data, MSB first
//   busy        out 1  frame in progress, through the inter-frame gap
//   frame_done  out 1  one-cycle pulse as spi_nCS returns high
module spi_mux_master
   import spi_mux_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned CS_SETUP = DEF_CS_SETUP,
   parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
   parameter int unsigned CS_IDLE  = DEF_CS_IDLE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   output logic              tx_ready,
   output logic              spi_nCS,
   output logic              spi_sck,
   output logic              spi_mosi,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned CNT_W = cnt_width(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE));

   // Timer reload values: a delay of P cycles loads P-1.
   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

   state_t               state;
   tx_beat_t             beat;
   logic [BIT_CNT_W-1:0] bit_cnt;

   logic                 hs_c;
   logic                 byte_end_c;
   logic                 tmr_load_c;
   logic [CNT_W-1:0]     tmr_val_c;
   logic                 tc_c;

   assign hs_c       = tx_valid && tx_ready;
   assign byte_end_c = (bit_cnt == LAST_BIT);

   // Timer reload on every state change that starts a timed interval.
   always_comb begin
      tmr_load_c = 1'b0;
      tmr_val_c  = DIV_LD;
      unique case (state)
         ST_IDLE: begin
            if (hs_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (tc_c) tmr_load_c = 1'b1;
         end
         ST_SHIFT: begin
            if (tc_c) begin
               tmr_load_c = 1'b1;
               // End of the final high phase of a frame's last byte starts the hold delay.
               if (spi_sck && byte_end_c && beat.last) tmr_val_c = HOLD_LD;
            end
         end
         ST_NEXT: begin
            if (hs_c) tmr_load_c = 1'b1;
         end
         ST_HOLD: begin
            if (tc_c) begin
               tmr_load_c = 1'b1;
               tmr_val_c  = IDLE_LD;
            end
         end
         default: begin
         end
      endcase
   end

   spi_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_c),
      .load_val (tmr_val_c),
      .tc_c     (tc_c)
   );

   // Frame sequencer with registered pin and handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         beat       <= '0;
         bit_cnt    <= '0;
         tx_ready   <= 1'b0;
         spi_nCS    <= 1'b1;
         spi_sck    <= 1'b0;
         spi_mosi   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               tx_ready <= 1'b1;
               if (hs_c) begin
                  beat     <= '{last: tx_last, data: tx_data};
                  bit_cnt  <= '0;
                  spi_nCS  <= 1'b0;
                  spi_mosi <= tx_data[BYTE_W-1];
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tc_c) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tc_c) begin
                  if (!spi_sck) begin
                     spi_sck <= 1'b1;
                  end else begin
                     // Falling edge: present the next bit, or finish the byte.
                     spi_sck <= 1'b0;
                     bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                     if (byte_end_c) begin
                        if (beat.last) begin
                           state <= ST_HOLD;
                        end else begin
                           tx_ready <= 1'b1;
                           state    <= ST_NEXT;
                        end
                     end else begin
                        beat.data <= {beat.data[BYTE_W-2:0], 1'b0};
                        spi_mosi  <= beat.data[BYTE_W-2];
                     end
                  end
               end
            end
            ST_NEXT: begin
               // Frame stays open with SCK low until the next byte arrives.
               if (hs_c) begin
                  beat     <= '{last: tx_last, data: tx_data};
                  spi_mosi <= tx_data[BYTE_W-1];
                  tx_ready <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_HOLD: begin
               if (tc_c) begin
                  spi_nCS    <= 1'b1;
                  frame_done <= 1'b1;
                  state      <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tc_c) begin
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mux_master.sv
// Self-checking bench for spi_mux_master: timeline-based reference model,
// per-cycle output comparison, pin-level monitor and directed plus random frames.
module tb_spi_mux_master;

   localparam int CD  = 2;
   localparam int CSS = 2;
   localparam int CSH = 2;
   localparam int CSI = 3;

   localparam int P_IDLE  = 0;
   localparam int P_SETUP = 1;
   localparam int P_BYTE  = 2;
   localparam int P_WAIT  = 3;
   localparam int P_HOLD  = 4;
   localparam int P_GAP   = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       spi_nCS;
   logic       spi_sck;
   logic       spi_mosi;
   logic       busy;
   logic       frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   spi_mux_master #(
      .CLK_DIV  (CD),
      .CS_SETUP (CSS),
      .CS_HOLD  (CSH),
      .CS_IDLE  (CSI)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .spi_nCS    (spi_nCS),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired at t=%0t", name, $time);
   endtask

   // ---------------- reference model: outputs from absolute cycle offsets
   int         ph = P_IDLE;
   int         m_cyc = 0;
   int         t0 = 0;
   int         bs = 0;
   logic       m_ready = 1'b0;
   logic       m_ncs = 1'b1;
   logic       m_sck = 1'b0;
   logic       m_mosi = 1'b0;
   logic       m_busy = 1'b0;
   logic       m_fd = 1'b0;
   logic [7:0] m_byte = 8'h00;
   logic       m_last = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph      <= P_IDLE;
         m_ready <= 1'b0;
         m_ncs   <= 1'b1;
         m_sck   <= 1'b0;
         m_mosi  <= 1'b0;
         m_busy  <= 1'b0;
         m_fd    <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
         m_fd  <= 1'b0;
         case (ph)
            P_IDLE: begin
               if (m_ready && tx_valid) begin
                  m_byte  <= tx_data;
                  m_last  <= tx_last;
                  exp_q.push_back(tx_data);
                  m_ncs   <= 1'b0;
                  m_mosi  <= tx_data[7];
                  m_busy  <= 1'b1;
                  m_ready <= 1'b0;
                  t0      <= m_cyc;
                  ph      <= P_SETUP;
               end else begin
                  m_ready <= 1'b1;
               end
            end
            P_SETUP: begin
               if (m_cyc - t0 == CSS) begin
                  bs <= m_cyc;
                  ph <= P_BYTE;
               end
            end
            P_BYTE: begin
               if (m_cyc - bs == 16 * CD) begin
                  m_sck <= 1'b0;
                  if (m_last) begin
                     t0 <= m_cyc;
                     ph <= P_HOLD;
                  end else begin
                     m_ready <= 1'b1;
                     ph      <= P_WAIT;
                  end
               end else begin
                  m_sck  <= (((m_cyc - bs) / CD) % 2) == 1;
                  m_mosi <= m_byte[3'(7 - (m_cyc - bs) / (2 * CD))];
               end
            end
            P_WAIT: begin
               if (tx_valid) begin
                  m_byte  <= tx_data;
                  m_last  <= tx_last;
                  exp_q.push_back(tx_data);
                  m_mosi  <= tx_data[7];
                  m_ready <= 1'b0;
                  bs      <= m_cyc;
                  ph      <= P_BYTE;
               end
            end
            P_HOLD: begin
               if (m_cyc - t0 == CSH) begin
                  m_ncs <= 1'b1;
                  m_fd  <= 1'b1;
                  t0    <= m_cyc;
                  ph    <= P_GAP;
               end
            end
            P_GAP: begin
               if (m_cyc - t0 == CSI) begin
                  m_busy  <= 1'b0;
                  m_ready <= 1'b1;
                  ph      <= P_IDLE;
               end
            end
            default: ph <= P_IDLE;
         endcase
      end
   end

   // ---------------- per-cycle comparison against the model
   always @(negedge clk) begin
      if (!reset) begin
         chk("cyc_nCS",   int'(spi_nCS),    int'(m_ncs));
         chk("cyc_sck",   int'(spi_sck),    int'(m_sck));
         chk("cyc_ready", int'(tx_ready),   int'(m_ready));
         chk("cyc_busy",  int'(busy),       int'(m_busy));
         chk("cyc_fdone", int'(frame_done), int'(m_fd));
         if (ph == P_SETUP || ph == P_BYTE)
            chk("cyc_mosi", int'(spi_mosi), int'(m_mosi));
      end
   end

   // ---------------- pin monitor (collects, does not judge)
   logic rx_bits[$];
   int   rise_cyc[$];
   int   ncs_len[$];
   int   ncyc = 0;
   int   low_run = 0;
   int   fd_count = 0;
   int   last_fd = 0;
   int   last_rdy_rise = 0;
   logic prev_sck = 1'b0;
   logic prev_rdy = 1'b0;

   always @(negedge clk) begin
      ncyc     <= ncyc + 1;
      prev_sck <= spi_sck;
      prev_rdy <= tx_ready;
      if (spi_sck && !prev_sck) begin
         rx_bits.push_back(spi_mosi);
         rise_cyc.push_back(ncyc);
      end
      if (!spi_nCS) begin
         low_run <= low_run + 1;
      end else if (low_run != 0) begin
         ncs_len.push_back(low_run);
         low_run <= 0;
      end
      if (frame_done) begin
         fd_count <= fd_count + 1;
         last_fd  <= ncyc;
      end
      if (tx_ready && !prev_rdy) last_rdy_rise <= ncyc;
   end

   function automatic int rx_word(input int n);
      int w = 0;
      for (int i = 0; i < n; i++)
         w = (w << 1) | ((i < rx_bits.size()) ? int'(rx_bits[i]) : 0);
      return w;
   endfunction

   function automatic int last_low();
      return (ncs_len.size() > 0) ? ncs_len[ncs_len.size() - 1] : -1;
   endfunction

   function automatic int rise_gap(input int i);
      return (i + 1 < rise_cyc.size()) ? rise_cyc[i + 1] - rise_cyc[i] : -1;
   endfunction

   // ---------------- driver helpers
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input int pre);
      int guard = 0;
      repeat (pre) step();
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      while (!m_ready && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) fail_now("send_wait");
      step();
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int guard = 0;
      step();
      while (!(ph == P_IDLE && m_ready) && guard < 3000) begin
         step();
         guard++;
      end
      if (guard >= 3000) fail_now({name, "_idle"});
      step();
      step();
   endtask

   // Received bytes against bytes the model accepted, then clear for the next test.
   task automatic check_stream(input string name);
      int nb = rx_bits.size() / 8;
      chk({name, "_nbytes"}, nb, exp_q.size());
      for (int i = 0; i < nb && i < exp_q.size(); i++) begin
         int b = 0;
         for (int j = 0; j < 8; j++) b = (b << 1) | int'(rx_bits[8 * i + j]);
         chk({name, "_byte"}, b, int'(exp_q[i]));
      end
      rx_bits.delete();
      rise_cyc.delete();
      exp_q.delete();
      ncs_len.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0;
      int guard;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      reset    = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      #1 chk("rdy_first_cycle", int'(tx_ready), 0);
      step();
      chk("rdy_after_edge", int'(tx_ready), 1);
      repeat (3) step();

      // reset asserted while idle
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_nCS",   int'(spi_nCS), 1);
      chk("rst_sck",   int'(spi_sck), 0);
      chk("rst_mosi",  int'(spi_mosi), 0);
      chk("rst_ready", int'(tx_ready), 0);
      chk("rst_busy",  int'(busy), 0);
      chk("rst_fdone", int'(frame_done), 0);
      repeat (2) step();
      reset = 1'b0;
      #1 chk("rel_ready0", int'(tx_ready), 0);
      step();
      chk("rel_ready1", int'(tx_ready), 1);
      repeat (2) step();
      check_stream("init");

      // single byte frame
      fd0 = fd_count;
      send_byte(8'hA5, 1'b1, 0);
      wait_idle("a5");
      chk("a5_bits",      rx_word(8), 'hA5);
      chk("a5_nbits",     rx_bits.size(), 8);
      chk("a5_ncs_low",   last_low(), 36);
      chk("a5_fdone",     fd_count - fd0, 1);
      chk("a5_rdy_delay", last_rdy_rise - last_fd, 3);
      chk("a5_bit_period", rise_gap(0), 4);
      check_stream("a5");

      // back-to-back two byte frame
      fd0 = fd_count;
      send_byte(8'h3C, 1'b0, 0);
      send_byte(8'hFF, 1'b1, 0);
      wait_idle("b2b");
      chk("b2b_nbits",   rx_bits.size(), 16);
      chk("b2b_bits",    rx_word(16), 'h3CFF);
      chk("b2b_ncs_low", last_low(), 69);
      chk("b2b_frames",  ncs_len.size(), 1);
      chk("b2b_fdone",   fd_count - fd0, 1);
      chk("b2b_gap",     rise_gap(7), 5);
      chk("b2b_period",  rise_gap(8), 4);
      check_stream("b2b");

      // second byte delayed: frame held open
      fd0 = fd_count;
      send_byte(8'h11, 1'b0, 0);
      guard = 0;
      while (!m_ready && guard < 200) begin
         step();
         guard++;
      end
      if (guard >= 200) fail_now("stall_reach");
      for (int i = 0; i < 10; i++) begin
         chk("stall_sck",   int'(spi_sck), 0);
         chk("stall_nCS",   int'(spi_nCS), 0);
         chk("stall_ready", int'(tx_ready), 1);
         step();
      end
      send_byte(8'hE7, 1'b1, 0);
      wait_idle("stall");
      chk("stall_bits",  rx_word(16), 'h11E7);
      chk("stall_fdone", fd_count - fd0, 1);
      check_stream("stall");

      // tx_valid toggled while not ready: nothing extra consumed
      fd0 = fd_count;
      send_byte(8'h5A, 1'b1, 0);
      guard = 0;
      while (!(ph == P_IDLE && m_ready) && guard < 500) begin
         tx_valid = m_ready ? 1'b0 : 1'($urandom_range(0, 1));
         tx_data  = 8'($urandom);
         tx_last  = 1'($urandom);
         step();
         guard++;
      end
      tx_valid = 1'b0;
      if (guard >= 500) fail_now("toggle_idle");
      repeat (3) step();
      chk("toggle_bits",  rx_word(8), 'h5A);
      chk("toggle_nbits", rx_bits.size(), 8);
      chk("toggle_fdone", fd_count - fd0, 1);
      check_stream("toggle");

      // reset during bit 4, then a clean frame
      fd0 = fd_count;
      send_byte(8'hC3, 1'b1, 0);
      guard = 0;
      while (rx_bits.size() < 4 && guard < 500) begin
         step();
         guard++;
      end
      if (guard >= 500) fail_now("midrst_reach");
      reset = 1'b1;
      #1;
      chk("midrst_nCS",   int'(spi_nCS), 1);
      chk("midrst_sck",   int'(spi_sck), 0);
      chk("midrst_busy",  int'(busy), 0);
      chk("midrst_fdone", int'(frame_done), 0);
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();
      chk("midrst_no_fd", fd_count - fd0, 0);
      rx_bits.delete();
      rise_cyc.delete();
      exp_q.delete();
      ncs_len.delete();
      fd0 = fd_count;
      send_byte(8'h81, 1'b1, 0);
      wait_idle("post_rst");
      chk("post_rst_bits",    rx_word(8), 'h81);
      chk("post_rst_ncs_low", last_low(), 36);
      chk("post_rst_fdone",   fd_count - fd0, 1);
      check_stream("post_rst");

      // random frames with random byte spacing
      fd0 = fd_count;
      for (int f = 0; f < 12; f++) begin
         int len = $urandom_range(1, 3);
         for (int b = 0; b < len; b++)
            send_byte(8'($urandom), (b == len - 1), $urandom_range(0, 3));
      end
      wait_idle("rand");
      chk("rand_frames", fd_count - fd0, 12);
      check_stream("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_mux_master.md
# spi_mux_master

SPI mode-0 master transmitter that feeds the LED output multiplexer from the controller side. It accepts bytes over a valid/ready stream, frames them under an active-low chip select, and shifts each byte MSB-first on `spi_mosi` against a divided `spi_sck`. One frame is one chip-select assertion; `tx_last` closes the frame. It sits between the frame-buffer readout logic and the off-chip SPI pins.

## Interface
- `CLK_DIV`, default 4: `spi_sck` half-period in `clk` cycles; minimum 1.
- `CS_SETUP`, default 2: `clk` cycles from `spi_nCS` falling to the start of the first SCK low phase; minimum 1.
- `CS_HOLD`, default 2: `clk` cycles from the final SCK falling edge to `spi_nCS` rising; minimum 1.
- `CS_IDLE`, default 4: minimum `clk` cycles `spi_nCS` stays high between frames; minimum 1.
- `clk` in 1: master clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data`/`tx_last` valid.
- `tx_last` in 1: this byte ends the frame.
- `tx_ready` out 1: block accepts a byte at this edge if `tx_valid`.
- `spi_nCS` out 1: chip select, active low.
- `spi_sck` out 1: serial clock, idle low.
- `spi_mosi` out 1: serial data, MSB first.
- `busy` out 1: high from accept of a frame's first byte until the end of the `CS_IDLE` gap.
- `frame_done` out 1: one-cycle pulse on the cycle `spi_nCS` returns high.

## Operation
- Every output is registered.
- Reset values, applied asynchronously: `spi_nCS`=1, `spi_sck`=0, `spi_mosi`=0, `tx_ready`=0, `busy`=0, `frame_done`=0; the state is IDLE.
- A handshake is `tx_valid && tx_ready` at a rising `clk` edge. No other event consumes data.
- IDLE: `tx_ready`=1, `spi_nCS`=1.
  - On handshake: load the shift register and last flag, drive `spi_nCS`=0 and `spi_mosi`=`tx_data[7]`, set `busy`=1, drop `tx_ready`, and go to SETUP.
- SETUP: hold for `CS_SETUP` cycles, then go to SHIFT.
- SHIFT: eight bits are sent.
  - Each bit has a low phase of `CLK_DIV` cycles with `spi_mosi` stable, then a high phase of `CLK_DIV` cycles.
  - The receiver samples on the rising `spi_sck` edge.
  - When `spi_sck` falls, the next bit is presented on the same edge.
  - After the eighth high phase ends (`spi_sck`=0):
    - if the last flag is set, go to HOLD;
    - otherwise go to NEXT.
- NEXT: `tx_ready`=1, `spi_sck`=0, `spi_nCS`=0.
  - On handshake: load the byte, present bit 7, and re-enter SHIFT.
  - With no handshake, the state stalls indefinitely with the frame held open.
- HOLD: hold for `CS_HOLD` cycles, then set `spi_nCS`=1 and pulse `frame_done`, and go to GAP.
- GAP: hold for `CS_IDLE` cycles, then clear `busy`, set `tx_ready`=1, and go to IDLE.
- Counters:
  - a 3-bit bit counter that wraps 7→0 at the end of a byte;
  - a phase/delay counter wide enough for max(`CLK_DIV`, `CS_SETUP`, `CS_HOLD`, `CS_IDLE`).
- Reset mid-frame aborts immediately: `spi_nCS` rises asynchronously, no `frame_done` is pulsed, and the partial byte is discarded.

## Timing
- First SCK rising edge: `CS_SETUP`+`CLK_DIV` cycles after `spi_nCS` falls.
- Byte period: 16·`CLK_DIV` cycles.
- Back-to-back bytes, with `tx_valid` high in the first NEXT cycle, add exactly one extra SCK-low cycle between bytes.
- Single-byte frame: `spi_nCS` is low for `CS_SETUP`+16·`CLK_DIV`+`CS_HOLD` cycles.
- After `frame_done`, `tx_ready` returns `CS_IDLE` cycles later.
- `tx_ready` is 0 in the first cycle after reset deasserts and rises at the first edge after that.

## Structure
- Package `spi_mux_pkg`:
  - state encoding (IDLE, SETUP, SHIFT, NEXT, HOLD, GAP);
  - default timing constants;
  - byte width constant 8.
- One sub-module, `spi_phase_timer`: a loadable down-counter with a terminal-count flag, used for the SETUP, HOLD and GAP delays and for SCK half-periods.

## Test plan
Use `CLK_DIV`=2, `CS_SETUP`=2, `CS_HOLD`=2, `CS_IDLE`=3.
- Reset asserted mid-idle → all outputs at their reset values; one edge after release, `tx_ready`=1.
- Single byte 0xA5 with `tx_last`=1 →
  - MOSI at the 8 SCK rising edges reads 1,0,1,0,0,1,0,1;
  - `spi_nCS` is low for 36 cycles;
  - one `frame_done` pulse;
  - `tx_ready` rises 3 cycles later.
- Frame 0x3C, 0xFF with `tx_valid` held high →
  - 16 rising edges under one `spi_nCS` assertion;
  - exactly one extra low cycle between bytes;
  - bits 0,0,1,1,1,1,0,0 then 1×8.
- Second byte delayed 10 cycles → `spi_sck`=0, `spi_nCS`=0 and `tx_ready`=1 through the stall; transmission resumes with bit 7 on the handshake.
- `tx_valid` toggled while `tx_ready`=0 → no byte consumed and transmitted data unchanged.
- Reset pulsed during bit 4 of a byte →
  - `spi_nCS`=1 and `spi_sck`=0 within the same cycle, no `frame_done`;
  - the next frame, 0x81, transmits correctly.
